quadrature_counter: RTL
=======================

QUADRATURE_COUNTER -- requirements
Module: quadrature_counter

Interface
REQ-001 Parameter WIDTH, default 16: position counter width; legal 2..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchroniser depth; legal 2..4.
REQ-003 Parameter FILTER_LEN, default 4: glitch-filter qualify length in clocks; legal 1..15.
REQ-004 Parameter MODE, default 2: counting resolution; 0 = x1, 1 = x2, 2 = x4; other values illegal.
REQ-005 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 A  input  1  encoder channel A, asynchronous to Clk.
REQ-008 B  input  1  encoder channel B, asynchronous to Clk.
REQ-009 Load  input  1  when high, Count takes Load_Value on the next edge.
REQ-010 Load_Value  input  WIDTH  preset value for Count.
REQ-011 Count  output  WIDTH  signed-agnostic position, modulo 2^WIDTH.
REQ-012 Dir  output  1  last legal direction; 1 = up (A leads B), 0 = down.
REQ-013 Step  output  1  one-cycle pulse on each counted transition.
REQ-014 Wrap  output  1  one-cycle pulse when a counted step wraps Count.
REQ-015 Error  output  1  one-cycle pulse on an illegal (double-bit) transition.

Function
REQ-016 A and B SHALL each pass through SYNC_STAGES flops before any other use.
REQ-017 Each channel SHALL have a filtered level that flips only after its synchronised value differs from it for FILTER_LEN consecutive cycles; any agreeing cycle restarts the run.
REQ-018 Filtered state {A,B} forward sequence SHALL be 00->10->11->01->00 (up); reverse sequence is down.
REQ-019 Every legal single-bit filtered transition SHALL update Dir, in every MODE.
REQ-020 Counted transitions: x4 = all legal transitions; x2 = legal transitions of A only; x1 = rising A only (00->10 up, 01->11 down).
REQ-021 On a counted transition, Count SHALL change by +1 (up) or -1 (down), and Step SHALL pulse.
REQ-022 Count, Dir, Step, Wrap and Error SHALL all update on the same edge.
REQ-023 Latency: a level change on A or B held stable SHALL produce Step exactly SYNC_STAGES+FILTER_LEN+1 rising edges after the first edge that samples it.
REQ-024 Count SHALL wrap max->0 on up and 0->max on down, with Wrap pulsing on that step.
REQ-025 If both filtered bits change in one cycle, Error SHALL pulse, and Count, Dir and Step SHALL be unchanged.
REQ-026 Load SHALL have priority over a simultaneous step.
  - Count = Load_Value.
  - Step and Dir still reflect the transition.
  - Wrap = 0.
REQ-027 Outside the stated events, Step, Wrap and Error SHALL be 0 and Count and Dir SHALL hold.

Reset
REQ-028 Reset SHALL clear synchronisers, filter run counters, filtered levels, Count, Dir, Step, Wrap and Error to 0 on the next edge, overriding Load and any in-flight transition.
REQ-029 Settle window: for SYNC_STAGES+FILTER_LEN cycles after Reset deasserts, filtered levels SHALL load the synchronised values directly, with no Step, Error or Count change.

Configuration
REQ-030 Macro QUADRATURE_COUNTER_INDEX_EN, when defined, SHALL add the following ports:
  - Z  input  1  index channel, synchronised via SYNC_STAGES flops.
  - Index  output  1  one-cycle pulse on the synchronised rising edge of Z.
  - On that edge, Count SHALL clear to 0.
  - Priority SHALL be Reset > Load > index clear > step; Wrap = 0 on an index clear.
REQ-031 When the macro is undefined, there SHALL be no Z or Index ports and no index logic; all other behaviour is identical.

Verification (WIDTH=8, SYNC_STAGES=2, FILTER_LEN=3, MODE=2; latency 6)
REQ-032 Reset, then AB steps 10,11,01,00, each held 10 cycles -> Count=4, Dir=1, four Step pulses, each 6 edges after its input change.
REQ-033 From Count=0, AB steps 01 then 11 -> Count=254, Dir=0, Wrap pulse on the first step only.
REQ-034 A 2-cycle glitch on A, then 00->11 held -> the glitch gives no Step; 00->11 gives one Error pulse and Count unchanged.
REQ-035 MODE=0, eight forward transitions -> Count=2; MODE=1 -> Count=4.
REQ-036 Load=1 with Load_Value=0x7F in the same cycle as a counted step -> Count=0x7F, Step=1, Wrap=0.
REQ-037 With QUADRATURE_COUNTER_INDEX_EN defined, Count=0x20, pulse Z high 5 cycles -> one Index pulse 3 edges after Z rises, Count=0.

Source files
------------

// File: rtl/quadrature_counter.sv
`default_nettype none
// ============================================================================
//  Module   : quadrature_counter
//  Purpose  : Quadrature encoder position counter. Channels A and B are
//             synchronised, glitch-filtered per channel, then decoded into
//             up/down steps at x1, x2 or x4 resolution. A modulo-2^WIDTH
//             position counter is maintained with load and wrap reporting.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       (2..32)  position counter width
//    SYNC_STAGES (2..4)   synchroniser depth for every asynchronous input
//    FILTER_LEN  (1..15)  cycles a new level must persist before acceptance
//    MODE        (0,1,2)  0 = x1, 1 = x2, 2 = x4 counting resolution
//  Ports
//    Clk         in   sole clock, rising edge
//    Reset       in   synchronous, active-high
//    A, B        in   encoder channels, asynchronous to Clk
//    Load        in   preset Count from Load_Value on the next edge
//    Load_Value  in   preset value (WIDTH bits)
//    Count       out  position, modulo 2^WIDTH
//    Dir         out  last legal direction, 1 = up (A leads B)
//    Step        out  one-cycle pulse per counted transition
//    Wrap        out  one-cycle pulse when a counted step wraps Count
//    Error       out  one-cycle pulse on a double-bit transition
//  Optional build macro QUADRATURE_COUNTER_INDEX_EN adds:
//    Z           in   index channel, asynchronous to Clk
//    Index       out  one-cycle pulse on the synchronised rising edge of Z,
//                     which also clears Count
// ============================================================================
module quadrature_counter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int MODE        = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             A,
    input  logic             B,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Value,
    output logic [WIDTH-1:0] Count,
    output logic             Dir,
    output logic             Step,
    output logic             Wrap,
    output logic             Error
`ifdef QUADRATURE_COUNTER_INDEX_EN
    ,
    input  logic             Z,
    output logic             Index
`endif
);

    // Settle window length after reset: long enough for the synchronisers
    // to fill and for the filters to see a full qualify run.
    localparam int               SETTLE_LEN  = SYNC_STAGES + FILTER_LEN;
    localparam logic [4:0]       SETTLE_DONE = 5'(SETTLE_LEN);
    localparam logic [3:0]       RUN_LAST    = 4'(FILTER_LEN - 1);
    localparam logic [WIDTH-1:0] COUNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [1:0]             sync_ab;     // {A,B} after synchronisation
    logic [1:0]             filt_ab;     // {A,B} after glitch filtering
    logic [1:0]             prev_ab;     // filt_ab one cycle earlier
    logic [3:0]             run_cnt [2]; // per-channel disagreement run
    logic [4:0]             settle_cnt;
    logic                   settling;

    assign sync_ab  = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    assign settling = (settle_cnt != SETTLE_DONE);

    // ------------------------------------------------------------------
    // Synchronisers, settle window and per-channel glitch filters.
    // Index 1 of filt_ab / run_cnt is channel A, index 0 is channel B.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_a     <= '0;
            sync_b     <= '0;
            settle_cnt <= '0;
            filt_ab    <= '0;
            prev_ab    <= '0;
            run_cnt[0] <= '0;
            run_cnt[1] <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], A};
            sync_b <= {sync_b[SYNC_STAGES-2:0], B};

            if (settling) begin
                // Adopt the synchronised levels outright; loading prev_ab
                // with the same value keeps the decoder silent.
                settle_cnt <= settle_cnt + 5'd1;
                filt_ab    <= sync_ab;
                prev_ab    <= sync_ab;
                run_cnt[0] <= '0;
                run_cnt[1] <= '0;
            end else begin
                prev_ab <= filt_ab;
                for (int i = 0; i < 2; i++) begin
                    if (sync_ab[i] != filt_ab[i]) begin
                        if (run_cnt[i] == RUN_LAST) begin
                            filt_ab[i] <= sync_ab[i];
                            run_cnt[i] <= '0;
                        end else begin
                            run_cnt[i] <= run_cnt[i] + 4'd1;
                        end
                    end else begin
                        // Any agreeing cycle restarts the qualify run.
                        run_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Transition decode. The Gray state {A,B} is mapped to a 2-bit
    // position 00->0, 10->1, 11->2, 01->3, so the modulo-4 difference
    // directly gives up (1), down (3) or illegal double-bit (2).
    // ------------------------------------------------------------------
    logic [1:0] pos_prev;
    logic [1:0] pos_cur;
    logic [1:0] delta;
    logic       moved;
    logic       is_up;
    logic       is_dn;
    logic       is_err;
    logic       counted;

    always_comb begin
        pos_prev = {prev_ab[0], prev_ab[1] ^ prev_ab[0]};
        pos_cur  = {filt_ab[0], filt_ab[1] ^ filt_ab[0]};
        delta    = pos_cur - pos_prev;
        moved    = !settling && (delta != 2'd0);
        is_up    = moved && (delta == 2'd1);
        is_dn    = moved && (delta == 2'd3);
        is_err   = moved && (delta == 2'd2);
        counted  = 1'b0;
        case (MODE)
            // x1: only rising A counts; B low means up, B high means down.
            0:       counted = (is_up || is_dn) && filt_ab[1] && !prev_ab[1];
            // x2: any legal transition that moves A.
            1:       counted = (is_up || is_dn) && (filt_ab[1] != prev_ab[1]);
            default: counted = is_up || is_dn;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional index channel.
    // ------------------------------------------------------------------
    logic index_rise;

`ifdef QUADRATURE_COUNTER_INDEX_EN
    logic [SYNC_STAGES-1:0] sync_z;
    logic                   z_prev;

    assign index_rise = sync_z[SYNC_STAGES-1] && !z_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_z <= '0;
            z_prev <= 1'b0;
            Index  <= 1'b0;
        end else begin
            sync_z <= {sync_z[SYNC_STAGES-2:0], Z};
            z_prev <= sync_z[SYNC_STAGES-1];
            Index  <= index_rise;
        end
    end
`else
    assign index_rise = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Position counter and registered status pulses.
    // Priority on Count: Load > index clear > step.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Count <= '0;
            Dir   <= 1'b0;
            Step  <= 1'b0;
            Wrap  <= 1'b0;
            Error <= 1'b0;
        end else begin
            Step  <= counted;
            Error <= is_err;
            Wrap  <= 1'b0;
            // Direction follows every legal transition, counted or not.
            if (is_up || is_dn) begin
                Dir <= is_up;
            end

            if (Load) begin
                Count <= Load_Value;
            end else if (index_rise) begin
                Count <= '0;
            end else if (counted) begin
                if (is_up) begin
                    Count <= Count + WIDTH'(1);
                    Wrap  <= (Count == COUNT_MAX);
                end else begin
                    Count <= Count - WIDTH'(1);
                    Wrap  <= (Count == '0);
                end
            end
        end
    end

endmodule
`default_nettype wire
